// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the fetch stage: NOP encoding, default reset PC,
//   the F->D register bundle, the fetch FSM state type and a word-align helper.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0033;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        nop;
    } fd_bundle_t;

    // A bubble in the FD register: decode ignores it.
    localparam fd_bundle_t FD_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, nop: 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,   // nothing outstanding at instruction memory
        ST_WAIT = 1'b1    // one request outstanding
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
//   One-entry {pc, instr} holding register that catches an instruction word
//   returning while decode is stalled.
// Ports
//   clk_i, reset_ni     clock, asynchronous active-low reset
//   clear_i             drop the held entry (redirect); wins over push/pop
//   push_i              capture push_pc_i / push_instr_i
//   pop_i               entry consumed by the FD register
//   valid_o, pc_o, instr_o  held entry
// ----------------------------------------------------------------------------
module fetch_skid_buffer (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_instr_i,
    input  logic        pop_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            // A push in the same cycle as a pop leaves the new word held.
            valid_d = 1'b1;
            pc_d    = push_pc_i;
            instr_d = push_instr_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 5-stage RV32 pipeline. Holds the PC, keeps
//   at most one request outstanding at instruction memory, buffers a word that
//   returns while decode is stalled and drives the F->D register. Redirects
//   come from execute (mispredict flush) and, at lower priority, from decode
//   (predicted taken control transfer).
// Ports
//   clk_i, reset_ni                     clock, asynchronous active-low reset
//   D_stall_i                           hold the FD register
//   E_flush_i, E_correctPC_i            execute redirect and its target
//   D_predictPC_i, D_PCprediction_i     decode redirect and its target
//   imem_req_o, imem_addr_o             request (always accepted), word address
//   imem_rvalid_i, imem_rdata_i         response to the outstanding request
//   FD_PC_o, FD_instr_o, FD_nop_o       F->D register
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        D_stall_i,
    input  logic        E_flush_i,
    input  logic [31:0] E_correctPC_i,
    input  logic        D_predictPC_i,
    input  logic [31:0] D_PCprediction_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] FD_PC_o,
    output logic [31:0] FD_instr_o,
    output logic        FD_nop_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         kill_q, kill_d;
    fd_bundle_t   fd_q, fd_d;

    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    logic         rsp_live;       // response for the outstanding request
    logic         rsp_ok;         // ... and it is not stale
    logic         pred_take;
    logic         redirect;
    logic [31:0]  redir_target;
    logic         slot_free;      // memory can take a request this cycle
    logic         skid_push;
    logic         skid_pop;
    logic         skid_busy_next;
    logic         issue;
    logic [31:0]  fetch_addr;

    assign rsp_live     = (state_q == ST_WAIT) && imem_rvalid_i;
    assign rsp_ok       = rsp_live && !kill_q;

    // A stalled decode has not committed to its prediction yet; it is
    // re-presented in the cycle the instruction leaves FD.
    assign pred_take    = D_predictPC_i && !D_stall_i && !E_flush_i;
    assign redirect     = E_flush_i || pred_take;
    assign redir_target = align_word(E_flush_i ? E_correctPC_i : D_PCprediction_i);

    assign slot_free      = (state_q == ST_IDLE) || rsp_live;
    assign skid_push      = !redirect && D_stall_i && rsp_ok;
    assign skid_pop       = !redirect && !D_stall_i && skid_valid;
    assign skid_busy_next = !redirect && D_stall_i && (skid_valid || rsp_ok);

    // Never fetch ahead of a held word: at most one instruction buffered.
    assign issue      = slot_free && !skid_busy_next;
    assign fetch_addr = redirect ? redir_target : pc_q;

    // The request is combinational; gate it so nothing issues while in reset.
    assign imem_req_o  = issue && reset_ni;
    assign imem_addr_o = fetch_addr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        kill_d    = kill_q;
        fd_d      = fd_q;

        // Any response ends the outstanding request; a stale one is dropped.
        if (rsp_live) begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
        end

        if (redirect) begin
            pc_d = redir_target;
            fd_d = FD_BUBBLE;
            // Request still in flight: mark it stale, reissue when it returns.
            if (!slot_free) begin
                kill_d = 1'b1;
            end
        end else if (!D_stall_i) begin
            if (skid_valid) begin
                fd_d = '{pc: skid_pc, instr: skid_instr, nop: 1'b0};
            end else if (rsp_ok) begin
                fd_d = '{pc: pend_pc_q, instr: imem_rdata_i, nop: 1'b0};
            end else begin
                fd_d = FD_BUBBLE;
            end
        end

        if (issue) begin
            state_d   = ST_WAIT;
            pc_d      = fetch_addr + 32'd4;
            pend_pc_d = fetch_addr;
            kill_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            pc_q      <= align_word(RESET_PC);
            pend_pc_q <= '0;
            kill_q    <= 1'b0;
            fd_q      <= FD_BUBBLE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
            fd_q      <= fd_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .clear_i      (redirect),
        .push_i       (skid_push),
        .push_pc_i    (pend_pc_q),
        .push_instr_i (imem_rdata_i),
        .pop_i        (skid_pop),
        .valid_o      (skid_valid),
        .pc_o         (skid_pc),
        .instr_o      (skid_instr)
    );

    assign FD_PC_o    = fd_q.pc;
    assign FD_instr_o = fd_q.instr;
    assign FD_nop_o   = fd_q.nop;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed scenarios plus a randomized run of fetch_unit against a memory
//   model with configurable latency and an expected-PC-stream reference.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        D_stall_i;
    logic        E_flush_i;
    logic [31:0] E_correctPC_i;
    logic        D_predictPC_i;
    logic [31:0] D_PCprediction_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] FD_PC_o;
    logic [31:0] FD_instr_o;
    logic        FD_nop_o;

    int tests = 0;
    int fails = 0;

    // memory model controls (written by main process)
    int lat       = 1;
    bit rand_lat  = 0;
    int stray_req = 0;
    // memory model state (written by memory process)
    int          stray_done = 0;
    bit          mem_pend   = 0;
    int          mem_cnt    = 0;
    logic [31:0] mem_addr   = '0;
    bit          saw_300    = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .D_stall_i        (D_stall_i),
        .E_flush_i        (E_flush_i),
        .E_correctPC_i    (E_correctPC_i),
        .D_predictPC_i    (D_predictPC_i),
        .D_PCprediction_i (D_PCprediction_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .FD_PC_o          (FD_PC_o),
        .FD_instr_o       (FD_instr_o),
        .FD_nop_o         (FD_nop_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory contents: a fixed hash of the address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory: requests sampled at negedge, responses driven just after posedge.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (stray_req != stray_done) begin
                stray_done    = stray_req;
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end else if (mem_pend && mem_cnt == 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mw(mem_addr);
                mem_pend      = 0;
            end else begin
                imem_rvalid_i = 1'b0;
                if (mem_pend) mem_cnt--;
            end
            @(negedge clk_i);
            if (!reset_ni) begin
                mem_pend = 0;
            end else if (imem_req_o) begin
                mem_pend = 1;
                mem_addr = imem_addr_o;
                mem_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat;
                if (imem_addr_o == 32'h300) saw_300 = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; D_stall_i = 0; E_flush_i = 0; D_predictPC_i = 0;
        E_correctPC_i = '0; D_PCprediction_i = '0;
        repeat (3) step();
        @(negedge clk_i);
        tests++; if (FD_nop_o !== 1'b1) begin fails++; $display("FAIL reset_nop: got %b want 1", FD_nop_o); end
        tests++; if (FD_PC_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", FD_PC_o); end
        tests++; if (FD_instr_o !== NOP) begin fails++; $display("FAIL reset_instr: got %h want %h", FD_instr_o, NOP); end
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
        step();
        reset_ni = 1'b1;
        @(negedge clk_i);
        tests++; if (imem_req_o !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", imem_req_o); end
        tests++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", imem_addr_o); end
        $display("[TB] reset: done");
    endtask

    task automatic test_stream();
        logic [31:0] e;
        step();
        @(negedge clk_i);
        tests++; if (FD_nop_o !== 1'b1) begin fails++; $display("FAIL stream_first_bubble: got %b want 1", FD_nop_o); end
        for (int k = 0; k < 4; k++) begin
            e = 32'(k * 4);
            step();
            @(negedge clk_i);
            tests++; if (FD_nop_o !== 1'b0 || FD_PC_o !== e || FD_instr_o !== mw(e)) begin
                fails++; $display("FAIL stream_pc: got pc %h instr %h nop %b want pc %h instr %h", FD_PC_o, FD_instr_o, FD_nop_o, e, mw(e));
            end
            $display("[TB] stream: FD_PC=%h", FD_PC_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        step();
        D_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge clk_i);
            tests++; if (FD_PC_o !== 32'h10 || FD_nop_o !== 1'b0) begin fails++; $display("FAIL stall_hold: got pc %h nop %b want pc 00000010", FD_PC_o, FD_nop_o); end
            tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL stall_noreq: got %b want 0", imem_req_o); end
        end
        step();
        D_stall_i = 1'b0;
        @(negedge clk_i);
        tests++; if (FD_PC_o !== 32'h10) begin fails++; $display("FAIL stall_release_hold: got %h want 00000010", FD_PC_o); end
        tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin fails++; $display("FAIL stall_release_req: got req %b addr %h want 1 00000018", imem_req_o, imem_addr_o); end
        for (int k = 0; k < 3; k++) begin
            e = 32'h14 + 32'(k * 4);
            step();
            @(negedge clk_i);
            tests++; if (FD_nop_o !== 1'b0 || FD_PC_o !== e || FD_instr_o !== mw(e)) begin
                fails++; $display("FAIL stall_resume: got pc %h nop %b want pc %h", FD_PC_o, FD_nop_o, e);
            end
        end
        $display("[TB] stall: done");
    endtask

    task automatic test_predict();
        step();
        D_predictPC_i = 1'b1; D_PCprediction_i = 32'h100;
        @(negedge clk_i);
        tests++; if (FD_PC_o !== 32'h20) begin fails++; $display("FAIL predict_fd: got %h want 00000020", FD_PC_o); end
        tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin fails++; $display("FAIL predict_req: got req %b addr %h want 1 00000100", imem_req_o, imem_addr_o); end
        step();
        D_predictPC_i = 1'b0;
        @(negedge clk_i);
        tests++; if (FD_nop_o !== 1'b1 || FD_instr_o !== NOP) begin fails++; $display("FAIL predict_bubble: got nop %b instr %h want 1 %h", FD_nop_o, FD_instr_o, NOP); end
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk_i);
            tests++; if (FD_nop_o !== 1'b0 || FD_PC_o !== 32'h100 + 32'(4 * k) || FD_instr_o !== mw(32'h100 + 32'(4 * k))) begin
                fails++; $display("FAIL predict_target: got pc %h nop %b want pc %h", FD_PC_o, FD_nop_o, 32'h100 + 32'(4 * k));
            end
        end
        $display("[TB] predict: done");
    endtask

    task automatic test_flush_wins();
        int n;
        lat = 3;
        n = 0;
        do begin step(); @(negedge clk_i); n++; end while (!imem_req_o && n < 10);
        step();
        E_flush_i = 1'b1; E_correctPC_i = 32'h200;
        D_predictPC_i = 1'b1; D_PCprediction_i = 32'h300;
        @(negedge clk_i);
        tests++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL flush_wait_noreq: got %b want 0", imem_req_o); end
        step();
        E_flush_i = 1'b0; D_predictPC_i = 1'b0;
        @(negedge clk_i);
        tests++; if (FD_nop_o !== 1'b1) begin fails++; $display("FAIL flush_bubble: got %b want 1", FD_nop_o); end
        step();
        @(negedge clk_i);
        tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin fails++; $display("FAIL flush_reissue: got req %b addr %h want 1 00000200", imem_req_o, imem_addr_o); end
        tests++; if (FD_nop_o !== 1'b1) begin fails++; $display("FAIL flush_killed: got nop %b pc %h want bubble", FD_nop_o, FD_PC_o); end
        n = 0;
        do begin step(); @(negedge clk_i); n++; end while (FD_nop_o && n < 10);
        tests++; if (FD_nop_o !== 1'b0 || FD_PC_o !== 32'h200 || FD_instr_o !== mw(32'h200)) begin
            fails++; $display("FAIL flush_target: got pc %h nop %b want pc 00000200", FD_PC_o, FD_nop_o);
        end
        tests++; if (saw_300 !== 1'b0) begin fails++; $display("FAIL flush_no_0x300: got fetched %b want 0", saw_300); end
        $display("[TB] flush_wins: done");
    endtask

    task automatic test_reset_wait();
        int n;
        lat = 3;
        n = 0;
        do begin step(); @(negedge clk_i); n++; end while (!imem_req_o && n < 10);
        step();
        reset_ni = 1'b0;
        @(negedge clk_i);
        tests++; if (imem_req_o !== 1'b0 || FD_nop_o !== 1'b1) begin fails++; $display("FAIL rstwait_in_reset: got req %b nop %b want 0 1", imem_req_o, FD_nop_o); end
        step();
        @(negedge clk_i);
        stray_req++;
        step();
        reset_ni = 1'b1;
        @(negedge clk_i);
        tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin fails++; $display("FAIL rstwait_restart: got req %b addr %h want 1 00000000", imem_req_o, imem_addr_o); end
        step();
        @(negedge clk_i);
        tests++; if (FD_nop_o !== 1'b1) begin fails++; $display("FAIL rstwait_stray: got nop %b pc %h instr %h want bubble", FD_nop_o, FD_PC_o, FD_instr_o); end
        n = 0;
        do begin step(); @(negedge clk_i); n++; end while (FD_nop_o && n < 10);
        tests++; if (FD_nop_o !== 1'b0 || FD_PC_o !== 32'h0 || FD_instr_o !== mw(32'h0)) begin
            fails++; $display("FAIL rstwait_first: got pc %h instr %h nop %b want pc 00000000", FD_PC_o, FD_instr_o, FD_nop_o);
        end
        $display("[TB] reset_wait: done");
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 2))
            0:       return $urandom & 32'h0000_3FFF;
            1:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: return $urandom;
        endcase
    endfunction

    // Reference: the FD stream is the sequential PC walk from the last
    // redirect target, with bubbles allowed, held on stall, bubble on redirect.
    task automatic test_random();
        logic        s_c, f_c, p_c, s_n, f_n, p_n;
        logic [31:0] tf_c, tp_c, tf_n, tp_n, exp_pc;
        logic [31:0] prev_pc, prev_instr;
        logic        prev_nop;
        int          bub, delivered;
        rand_lat = 1;
        s_c = 0; f_c = 0; p_c = 0; tf_c = '0; tp_c = '0;
        exp_pc = '0; prev_pc = '0; prev_instr = '0; prev_nop = 1; bub = 0; delivered = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            s_n  = ($urandom_range(0, 3) == 0);
            f_n  = (i == 0) || ($urandom_range(0, 29) == 0);
            p_n  = !FD_nop_o && ($urandom_range(0, 9) == 0);
            tf_n = (i == 0) ? 32'h1000 : rand_target();
            tp_n = rand_target();
            D_stall_i = s_n; E_flush_i = f_n; E_correctPC_i = tf_n;
            D_predictPC_i = p_n; D_PCprediction_i = tp_n;
            @(negedge clk_i);
            if (i > 0) begin
                tests++;
                if (f_c || (p_c && !s_c)) begin
                    if (FD_nop_o !== 1'b1 || FD_instr_o !== NOP) begin
                        fails++; $display("FAIL rand_redirect_bubble cyc %0d: got nop %b instr %h want 1 %h", i, FD_nop_o, FD_instr_o, NOP);
                    end
                    exp_pc = (f_c ? tf_c : tp_c) & 32'hFFFF_FFFC;
                end else if (s_c) begin
                    if (FD_PC_o !== prev_pc || FD_instr_o !== prev_instr || FD_nop_o !== prev_nop) begin
                        fails++; $display("FAIL rand_stall_hold cyc %0d: got %h/%h/%b want %h/%h/%b", i, FD_PC_o, FD_instr_o, FD_nop_o, prev_pc, prev_instr, prev_nop);
                    end
                end else if (FD_nop_o === 1'b0) begin
                    if (FD_PC_o !== exp_pc || FD_instr_o !== mw(exp_pc)) begin
                        fails++; $display("FAIL rand_stream cyc %0d: got pc %h instr %h want pc %h instr %h", i, FD_PC_o, FD_instr_o, exp_pc, mw(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
                if (!s_c && FD_nop_o) bub++; else bub = 0;
                tests++;
                if (bub > 12) begin
                    fails++; $display("FAIL rand_progress cyc %0d: got %0d bubbles want <= 12", i, bub);
                    bub = 0;
                end
            end
            prev_pc = FD_PC_o; prev_instr = FD_instr_o; prev_nop = FD_nop_o;
            s_c = s_n; f_c = f_n; p_c = p_n; tf_c = tf_n; tp_c = tp_n;
        end
        D_stall_i = 0; E_flush_i = 0; D_predictPC_i = 0;
        $display("[TB] random: %0d instructions delivered", delivered);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_predict();
        test_flush_wins();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
